// File: rtl/neural_soc_key_pkg.sv
// Shared constants for the push-button controller: register map and debouncer states.
package neural_soc_key_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

endpackage

// File: rtl/neural_soc_key_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
interface neural_soc_key_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/neural_soc_key_debounce.sv
// Single-key debouncer: a level change is accepted only after it has been
// held against the debounced level for DEBOUNCE_CYCLES counted cycles.
module neural_soc_key_debounce
    import neural_soc_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic db,
    output logic fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             db_reg;
    logic             differ;
    logic             accept;

    assign differ = (sync_in != db_reg);
    assign accept = (state_reg == COUNT) && differ && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
            db_reg    <= 1'b1;
        end else begin
            case (state_reg)
                STABLE: begin
                    if (differ) begin
                        state_reg <= COUNT;
                        cnt_reg   <= '0;
                    end
                end
                COUNT: begin
                    if (!differ) begin
                        state_reg <= STABLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg    <= sync_in;
                        state_reg <= STABLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= STABLE;
            endcase
        end
    end

    assign db = db_reg;
    // Asserted in the cycle before db drops, so the press edge lands on the same clock.
    assign fall = accept & ~sync_in;

endmodule

// File: rtl/neural_soc_key_ctrl.sv
// Push-button controller with Avalon-MM register map and level interrupt.
// Define NEURAL_SOC_KEY_DEBOUNCE_EN to insert per-key debouncers; otherwise db = sync.
module neural_soc_key_ctrl
    import neural_soc_key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    neural_soc_key_ctrl_if.slave  bus,
    input  logic [N_KEYS-1:0]     in_port,
    output logic                  irq
);
    if (N_KEYS < 1 || N_KEYS > 32) begin : g_bad_keys
        $error("N_KEYS must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_KEYS-1:0] meta_reg;
    logic [N_KEYS-1:0] sync_reg;
    logic [N_KEYS-1:0] db;
    logic [N_KEYS-1:0] fall;
    logic [N_KEYS-1:0] edge_reg;
    logic [N_KEYS-1:0] mask_reg;
    logic [N_KEYS-1:0] edge_clr;
    logic [31:0]       readdata_reg;
    logic [31:0]       readdata_next;
    logic              wr_en;

    // Keys idle high, so the synchronizer resets to ones to avoid a press at release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= '1;
            sync_reg <= '1;
        end else begin
            meta_reg <= in_port;
            sync_reg <= meta_reg;
        end
    end

`ifdef NEURAL_SOC_KEY_DEBOUNCE_EN
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_debounce
        neural_soc_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .sync_in (sync_reg[gi]),
            .db      (db[gi]),
            .fall    (fall[gi])
        );
    end
`else
    assign db   = sync_reg;
    assign fall = sync_reg & ~meta_reg;
`endif

    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign edge_clr = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[N_KEYS-1:0] : '0;

    // Set after clear, so a press coinciding with a clear write survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_reg <= '0;
            mask_reg <= '0;
        end else begin
            edge_reg <= (edge_reg & ~edge_clr) | fall;
            if (wr_en && bus.address == ADDR_MASK) begin
                mask_reg <= bus.writedata[N_KEYS-1:0];
            end
        end
    end

    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA: readdata_next[N_KEYS-1:0] = db;
            ADDR_RAW:  readdata_next[N_KEYS-1:0] = sync_reg;
            ADDR_MASK: readdata_next[N_KEYS-1:0] = mask_reg;
            ADDR_EDGE: readdata_next[N_KEYS-1:0] = edge_reg;
            default:   readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= readdata_next;
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq          = |(edge_reg & mask_reg);

    if (N_KEYS < 32) begin : g_unused_wd
        logic unused_writedata;
        assign unused_writedata = &{1'b0, bus.writedata[31:N_KEYS]};
    end

endmodule
